// File: rtl/mod_mul_sequencer.sv
`timescale 1ns/1ps
// mod_mul_sequencer
//   Computes result = (a*b) mod M, where M = 2^N - k. It uses MSB-first
//   double-and-add and sends at most one modular addition per cycle
//   through a single shared modulo adder.
//   k is latched with each operation, so k may differ from one operation to the next.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake for a, b, k
//   a, b                  operands, expected < M
//   k                     modulus offset, legal range 3 .. 2^(N-1)-1
//   out_valid/out_ready   result handshake
//   result                (a*b) mod M, or 0 when err=1
//   err                   operands were illegal; nothing was computed
//   busy                  doubling or adding in progress
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// DBL   | acc <= 2*acc mod M for bit idx of b
// ADD   | acc <= acc + a mod M because bit idx of b is set
// DONE  | presenting result/err until out_ready
module mod_mul_sequencer #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         err,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N:0] TWO_N = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_reg, b_reg, k_reg, acc;
  logic [IW-1:0] idx;

  logic [N-1:0]  add_y, add_sum;
  logic [N:0]    raw_sum;
  logic [N+1:0]  off_sum;
  logic [N:0]    m_in;
  logic          illegal;

  // Shared modulo adder. Both inputs are < M, so raw_sum < 2M. Adding k
  // carries past 2^N exactly when raw_sum >= M, and the low N bits are then
  // raw_sum - M.
  always_comb begin
    add_y   = (state == ADD) ? a_reg : acc;
    raw_sum = {1'b0, acc} + {1'b0, add_y};
    off_sum = {1'b0, raw_sum} + {2'b00, k_reg};
    add_sum = (off_sum[N+1:N] != 2'b00) ? off_sum[N-1:0] : raw_sum[N-1:0];
  end

  always_comb begin
    m_in    = TWO_N - {1'b0, k};
    illegal = (k < N'(3)) || k[N-1] ||
              ({1'b0, a} >= m_in) || ({1'b0, b} >= m_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      k_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      result    <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            k_reg    <= k;
            acc      <= '0;
            idx      <= IW'(N - 1);
            in_ready <= 1'b0;
            if (illegal) begin
              state     <= DONE;
              err       <= 1'b1;
              result    <= '0;
              out_valid <= 1'b1;
            end else begin
              state <= DBL;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        DBL: begin
          acc <= add_sum;
          if (b_reg[idx]) begin
            state <= ADD;
          end else if (idx == '0) begin
            state     <= DONE;
            result    <= add_sum;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        ADD: begin
          acc <= add_sum;
          if (idx == '0) begin
            state     <= DONE;
            result    <= add_sum;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx   <= idx - IW'(1);
            state <= DBL;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_sequencer.sv
`timescale 1ns/1ps
module tb_mod_mul_sequencer;
  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] k = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         err;
  logic         busy;

  int checks = 0;
  int failures = 0;

  mod_mul_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic bit ref_illegal(int ia, int ib, int ik);
    int m;
    m = (1 << N) - ik;
    return (ik < 3) || (ik >= (1 << (N - 1))) || (ia >= m) || (ib >= m);
  endfunction

  function automatic int ref_result(int ia, int ib, int ik);
    if (ref_illegal(ia, ib, ik)) return 0;
    return (ia * ib) % ((1 << N) - ik);
  endfunction

  function automatic int ref_latency(int ia, int ib, int ik);
    if (ref_illegal(ia, ib, ik)) return 0;
    return N + $countones(ib);
  endfunction

  // Runs one operation; lat counts clock edges from accept to out_valid seen.
  // bad counts handshake/status violations seen along the way.
  task automatic do_op(input int ia, input int ib, input int ik, input int stall,
                       output int r, output int e, output int lat,
                       output int bad, output int to);
    int n;
    logic [N-1:0] r_hold;
    logic         e_hold;
    r = 0; e = 0; lat = 0; bad = 0; to = 0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin to = 1; return; end
    a = N'(ia); b = N'(ib); k = N'(ik);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 3 * N) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1; n++;
    end
    if (out_valid !== 1'b1) begin to = 1; return; end
    lat = n;
    r_hold = result;
    e_hold = err;
    r = int'(r_hold);
    e = int'(e_hold);
    if (busy !== 1'b0 || in_ready !== 1'b0) bad++;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== r_hold || err !== e_hold || in_ready !== 1'b0) bad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int ta[6] = '{7, 124, 100, 55, 64, 10};
    int tb[6] = '{9, 124, 100, 0, 64, 12};
    int tk[6] = '{3, 3, 3, 3, 63, 3};
    int te[6] = '{63, 1, 0, 0, 1, 120};
    int r, e, lat, bad, to;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tk[i], 0, r, e, lat, bad, to);
      checks++; if (to != 0) begin failures++; $display("FAIL dir%0d_timeout got=%0d exp=0", i, to); end
      checks++; if (r != te[i]) begin failures++; $display("FAIL dir%0d_result got=%0d exp=%0d", i, r, te[i]); end
      checks++; if (e != 0) begin failures++; $display("FAIL dir%0d_err got=%0d exp=0", i, e); end
      checks++; if (lat != N + $countones(tb[i])) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, N + $countones(tb[i])); end
      checks++; if (bad != 0) begin failures++; $display("FAIL dir%0d_protocol got=%0d exp=0", i, bad); end
    end
  endtask

  task automatic test_error();
    int ta[5] = '{5, 125, 3, 5, 5};
    int tb[5] = '{5, 3, 125, 5, 5};
    int tk[5] = '{2, 3, 3, 64, 0};
    int r, e, lat, bad, to;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tk[i], 1, r, e, lat, bad, to);
      checks++; if (to != 0) begin failures++; $display("FAIL err%0d_timeout got=%0d exp=0", i, to); end
      checks++; if (e != 1) begin failures++; $display("FAIL err%0d_err got=%0d exp=1", i, e); end
      checks++; if (r != 0) begin failures++; $display("FAIL err%0d_result got=%0d exp=0", i, r); end
      checks++; if (lat != 0) begin failures++; $display("FAIL err%0d_latency got=%0d exp=0", i, lat); end
      checks++; if (bad != 0) begin failures++; $display("FAIL err%0d_protocol got=%0d exp=0", i, bad); end
    end
  endtask

  task automatic test_back_to_back();
    int r, e, lat, bad, to;
    do_op(7, 9, 3, 5, r, e, lat, bad, to);
    checks++; if (to != 0 || r != 63) begin failures++; $display("FAIL stall_result got=%0d exp=63 timeout=%0d", r, to); end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", bad); end
    do_op(67, 67, 60, 0, r, e, lat, bad, to);
    checks++; if (to != 0 || r != 1) begin failures++; $display("FAIL b2b_result got=%0d exp=1 timeout=%0d", r, to); end
    checks++; if (e != 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", e); end
    checks++; if (lat != N + 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, N + 3); end
  endtask

  task automatic test_async_reset();
    int r, e, lat, bad, to;
    a = N'(7); b = N'(9); k = N'(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(10, 12, 3, 0, r, e, lat, bad, to);
    checks++; if (to != 0 || r != 120) begin failures++; $display("FAIL post_rst_result got=%0d exp=120 timeout=%0d", r, to); end
    checks++; if (lat != N + 2 || bad != 0) begin failures++; $display("FAIL post_rst_timing got=%0d exp=%0d bad=%0d", lat, N + 2, bad); end
  endtask

  task automatic test_random();
    int ia, ib, ik, m, r, e, lat, bad, to, er, el;
    for (int i = 0; i < 80; i++) begin
      ik = $urandom_range(3, (1 << (N - 1)) - 1);
      m = (1 << N) - ik;
      ia = $urandom_range(0, m - 1);
      ib = $urandom_range(0, m - 1);
      case ($urandom_range(0, 9))
        0: ik = $urandom_range(0, 2);
        1: ia = $urandom_range(m, (1 << N) - 1);
        2: ik = $urandom_range(1 << (N - 1), (1 << N) - 1);
        default: ;
      endcase
      er = ref_result(ia, ib, ik);
      el = ref_latency(ia, ib, ik);
      do_op(ia, ib, ik, $urandom_range(0, 3), r, e, lat, bad, to);
      checks++;
      if (to != 0 || r != er || e != int'(ref_illegal(ia, ib, ik)) || lat != el || bad != 0) begin
        failures++;
        $display("FAIL rnd%0d a=%0d b=%0d k=%0d got r=%0d e=%0d lat=%0d bad=%0d to=%0d exp r=%0d e=%0d lat=%0d",
                 i, ia, ib, ik, r, e, lat, bad, to, er, ref_illegal(ia, ib, ik), el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
